// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension unit: mode encodings and mode type.
package ext_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO  = 2'b00;
  localparam ext_mode_t EXT_SIGN  = 2'b01;
  localparam ext_mode_t EXT_UPPER = 2'b10;
  localparam ext_mode_t EXT_BYTE  = 2'b11;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension: widens an IN_W field to OUT_W according to mode,
// with an enable gate that forces the result to zero.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  data,
  input  ext_mode_t        mode,
  input  logic             enable,
  output logic [OUT_W-1:0] result
);

  logic signed [IN_W-1:0] data_s;
  logic signed [7:0]      byte_s;

  assign data_s = $signed(data);
  assign byte_s = $signed(data[7:0]);

  always_comb begin
    result = '0;
    if (enable) begin
      unique case (mode)
        EXT_ZERO:  result = OUT_W'(data);
        EXT_SIGN:  result = OUT_W'(data_s);
        // With OUT_W == IN_W the shift is zero and the field passes through unchanged
        EXT_UPPER: result = OUT_W'(data) << (OUT_W - IN_W);
        EXT_BYTE:  result = OUT_W'(byte_s);
        default:   result = '0;
      endcase
    end
  end

endmodule

// File: rtl/ext_unit_pipe.sv
// Immediate-extension unit with valid/ready handshake and a 2-entry output buffer.
// in_ready depends only on occupancy, so there is no combinational out_ready->in_ready path.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_count
);

  logic [OUT_W-1:0] mem [DEPTH];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [OUT_W-1:0] ext_res;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_next;
  logic             push;
  logic             pop;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data   (in_data),
    .mode   (in_mode),
    .enable (in_enable),
    .result (ext_res)
  );

  assign in_ready  = (count != 2'd2) && !rst;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_q;
  assign out_count = count;

  // Head value for the next cycle; a fresh result bypasses storage when it becomes the head
  always_comb begin
    out_next = out_q;
    if (pop) begin
      if (count == 2'd2)
        out_next = mem[~head];
      else if (push)
        out_next = ext_res;
    end else if (count == 2'd0 && push) begin
      out_next = ext_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
      out_q <= '0;
    end else begin
      if (push) begin
        mem[tail] <= ext_res;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      out_q <= out_next;
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Scoreboard bench for ext_unit_pipe: directed vectors, randomized traffic against an
// arithmetic reference model, reset mid-operation, and two parameter variants.
module tb_ext_unit_pipe;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        in_enable;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_count;

  // Parameter-variant instances
  logic        p_valid;
  logic        p16_ready, p16_valid, p8_ready, p8_valid;
  logic [15:0] p16_data, p8_data;
  logic [1:0]  p16_count, p8_count;
  logic [1:0]  p16_mode, p8_mode;
  logic [15:0] p16_in;
  logic [7:0]  p8_in;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_val = '0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_enable(in_enable), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  ext_unit_pipe #(.IN_W(16), .OUT_W(16), .DEPTH(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(p16_ready), .in_data(p16_in),
    .in_mode(p16_mode), .in_enable(1'b1), .out_valid(p16_valid), .out_ready(1'b1),
    .out_data(p16_data), .out_count(p16_count)
  );

  ext_unit_pipe #(.IN_W(8), .OUT_W(16), .DEPTH(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(p8_ready), .in_data(p8_in),
    .in_mode(p8_mode), .in_enable(1'b1), .out_valid(p8_valid), .out_ready(1'b1),
    .out_data(p8_data), .out_count(p8_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: extension rules as plain arithmetic on 16-bit field / 32-bit result
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m,
                                          input logic en);
    longint v, b;
    v = longint'(d);
    b = v % 256;
    if (!en) return 32'd0;
    case (m)
      2'd0:    return 32'(v);
      2'd1:    return 32'((v >= 32768) ? v + 64'h1_0000_0000 - 65536 : v);
      2'd2:    return 32'(v * 65536);
      default: return 32'((b >= 128) ? b + 64'h1_0000_0000 - 256 : b);
    endcase
  endfunction

  // Monitor: state checks plus pop-and-compare on every handshake
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_count", 64'(out_count), 64'(exp_q.size()));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'((exp_q.size() != 2) && !rst));
      if (!out_valid) check("out_data_hold", 64'(out_data), 64'(last_val));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        last_val = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(last_val));
      end
    end
  end

  // One cycle of stimulus; records the expected result when the field is accepted
  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m,
                       input logic en, input logic rdy, input logic r,
                       input bit use_exp, input logic [31:0] exp, output bit acc);
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_mode = m; in_enable = en; out_ready = rdy; rst = r;
    @(negedge clk); #1;
    acc = in_valid && in_ready && !rst;
    if (rst) begin
      exp_q.delete();
      last_val = '0;
    end else if (acc) begin
      exp_q.push_back(use_exp ? exp : ref_ext(d, m, en));
    end
  endtask

  typedef struct { logic [15:0] d; logic [1:0] m; logic en; logic [31:0] exp; } vec_t;
  vec_t vecs[7];

  initial begin
    bit acc;
    vecs[0] = '{16'h4AA2, EXT_ZERO,  1'b1, 32'h00004AA2};
    vecs[1] = '{16'h4AA2, EXT_SIGN,  1'b1, 32'h00004AA2};
    vecs[2] = '{16'h4AA2, EXT_UPPER, 1'b1, 32'h4AA20000};
    vecs[3] = '{16'h4AA2, EXT_BYTE,  1'b1, 32'hFFFFFFA2};
    vecs[4] = '{16'h8AA2, EXT_SIGN,  1'b1, 32'hFFFF8AA2};
    vecs[5] = '{16'h8AA2, EXT_ZERO,  1'b1, 32'h00008AA2};
    vecs[6] = '{16'h4AA2, EXT_UPPER, 1'b0, 32'h00000000};

    rst = 1'b1; in_valid = 0; in_data = '0; in_mode = '0; in_enable = 0; out_ready = 0;
    p_valid = 0; p16_in = 16'h4AA2; p16_mode = EXT_UPPER; p8_in = 8'h80; p8_mode = EXT_BYTE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Directed vectors with fixed expected values
    foreach (vecs[i]) drive(1, vecs[i].d, vecs[i].m, vecs[i].en, 1, 0, 1, vecs[i].exp, acc);
    repeat (2) drive(0, 0, 0, 0, 1, 0, 0, 0, acc);

    // Backpressure: A1, B2 fill the buffer, C3 waits
    drive(1, 16'h00A1, EXT_ZERO, 1, 0, 0, 1, 32'h000000A1, acc);
    drive(1, 16'h00B2, EXT_ZERO, 1, 0, 0, 1, 32'h000000B2, acc);
    repeat (3) begin
      drive(1, 16'h00C3, EXT_ZERO, 1, 0, 0, 1, 32'h000000C3, acc);
      check("c3_held", 64'(acc), 64'(0));
    end
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++)
      drive(1, 16'h00C3, EXT_ZERO, 1, 1, 0, 1, 32'h000000C3, acc);
    check("c3_accepted", 64'(acc), 64'(1));
    repeat (3) drive(0, 0, 0, 0, 1, 0, 0, 0, acc);

    // Occupancy 1 with simultaneous push and pop
    drive(1, 16'h1111, EXT_SIGN, 1, 0, 0, 0, 0, acc);
    for (int i = 0; i < 4; i++)
      drive(1, 16'h8000 + 16'(i), EXT_SIGN, 1, 1, 0, 0, 0, acc);
    repeat (2) drive(0, 0, 0, 0, 1, 0, 0, 0, acc);

    // Reset while full with a field presented
    drive(1, 16'h0001, EXT_ZERO, 1, 0, 0, 0, 0, acc);
    drive(1, 16'h0002, EXT_ZERO, 1, 0, 0, 0, 0, acc);
    drive(1, 16'h0003, EXT_ZERO, 1, 0, 1, 0, 0, acc);
    check("rst_no_accept", 64'(acc), 64'(0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, acc);
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 199) == 0), 0, 0, acc);
    rst = 1'b0;
    repeat (4) drive(0, 0, 0, 0, 1, 0, 0, 0, acc);
    check("drained", 64'(exp_q.size()), 64'(0));

    // Parameter variants
    @(posedge clk); #1 p_valid = 1'b1;
    @(posedge clk); #1 p_valid = 1'b0;
    @(negedge clk);
    check("p16_valid", 64'(p16_valid), 64'(1));
    check("p16_upper", 64'(p16_data), 64'(16'h4AA2));
    check("p8_valid", 64'(p8_valid), 64'(1));
    check("p8_byte", 64'(p8_data), 64'(16'hFF80));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
